alu_bit_sequencer: RTL and testbench
====================================

Name: alu_bit_sequencer

Overview:
- Drives the existing 1-bit serial ALU slice (project3) across a W-bit word, LSB first.
- Each bit's carry (Y1) is fed back as the next bit's Cin; each sum bit (Y0) is collected into a result register.
- Sits directly upstream of the slice and consumes its terminal pulses. Turns the slice into a multi-cycle W-bit AND/OR/ADD/SUB unit with a start/done handshake.

Parameters:
- W, 8, operand and result width in bits (≥2).
- TIMEOUT, 15, max cycles to wait for any slice terminal pulse (used only with ALU_SEQ_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  00 AND, 01 OR, 10 ADD, 11 illegal; passed through to the slice.
- binv  input  1  invert B; also the Cin of bit 0 (SUB = op 10 with binv 1).
- a  input  W  operand A.
- b  input  W  operand B.
- busy  output  1  high in SYNC and RUN.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  W  assembled word; held until the next accepted start.
- carry_out  output  1  Y1 of the MSB.
- zero_flag  output  1  result == 0, valid with done.
- err  output  1  illegal op, or timeout; valid with done.
- alu_a, alu_b, alu_op0, alu_op1, alu_binv, alu_cin  output  1 each  registered drive to the slice.
- alu_error, alu_zero, alu_y0, alu_y1  input  1 each  slice terminal pulses.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All outputs 0, except alu_op1=alu_op0=1.
- Terminal pulse: term = alu_error|alu_zero|alu_y0|alu_y1.
  - The slice returns to its start state on the cycle after any terminal pulse and samples op1 that cycle.
  - All alu_* drives therefore update only on the clock edge where term=1, and are held stable otherwise.
- IDLE:
  - alu_op=11, alu_a/b/binv/cin=0, so the slice spins in its 3-cycle error loop.
  - Slice pulses are ignored.
  - start=1: latch a, b, op, binv; go to SYNC.
- SYNC:
  - Wait for term.
  - On that edge, drive bit 0: alu_a=a[0], alu_b=b[0], alu_op=op, alu_binv=binv, alu_cin=binv.
  - Clear the bit index; go to RUN.
- RUN, on each edge with term=1:
  - If alu_error: clear result, set err=1, go to DONE.
  - Else: result[idx] <= alu_y0 and carry <= alu_y1.
  - If idx==W-1: carry_out <= alu_y1, go to DONE, drive idle values.
  - Else: idx++, drive bit idx+1 with alu_cin=alu_y1.
- Priority when several slice pulses coincide (protocol violation): error > (y0, y1 as given); alu_zero implies sum=0, carry=0.
- DONE:
  - done=1 for exactly one cycle; zero_flag=(result==0).
  - Go to IDLE.
  - Drives are already idle (op 11).
- start while busy or in DONE is ignored.
- Latency: per bit 5–8 cycles depending on the slice path. Total = SYNC wait (≤3) + W bit times + 1.
- Reset mid-operation aborts immediately: no done, result cleared.

Optional Feature:
- ALU_SEQ_TIMEOUT_EN defined:
  - A counter clears on entry to SYNC/RUN and on every term.
  - If it reaches TIMEOUT, go to DONE with err=1 and result=0.
- Not defined: no counter; SYNC/RUN wait indefinitely.

Decomposition:
- Package alu_seq_pkg:
  - seq_state_t enum {IDLE, SYNC, RUN, DONE}.
  - Op constants OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_ILL=2'b11.
  - Idle-drive constant.
- One sub-module, alu_result_shifter:
  - Index counter plus result/carry capture.
  - Controlled by load/capture/clear strobes from the FSM.

Test Plan:
- W=8, op=10, binv=0, a=0x05, b=0x03 -> result=0x08, carry_out=0, zero_flag=0, err=0, done pulses once.
- op=10, binv=1, a=0x05, b=0x03 -> result=0x02, carry_out=1.
- op=10, binv=0, a=0xFF, b=0x01 -> result=0x00, carry_out=1, zero_flag=1.
- op=00, a=0xF0, b=0x3C -> result=0x30. Then op=01, same operands -> result=0xFC.
- op=11 -> done after the first slice error pulse, err=1, result=0x00. A second start pulsed while busy is ignored.
- Reset (reset=0) mid-RUN at bit 4 -> busy=0, result=0, no done. A fresh ADD afterwards completes correctly. With ALU_SEQ_TIMEOUT_EN, holding the slice in reset -> err=1 after TIMEOUT cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the W-bit sequencer around the 1-bit serial ALU slice.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef struct packed {
    logic a;
    logic b;
    logic op1;
    logic op0;
    logic binv;
    logic cin;
  } alu_drive_t;

  // Illegal op keeps the slice cycling through its short error loop while idle.
  localparam alu_drive_t IDLE_DRIVE = '{a: 1'b0, b: 1'b0, op1: 1'b1, op0: 1'b1,
                                        binv: 1'b0, cin: 1'b0};

endpackage

// File: rtl/alu_result_shifter.sv
// Bit index counter plus result/carry capture, strobed by the sequencer FSM.
module alu_result_shifter #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic          capture_i,
  input  logic          sum_i,
  input  logic          carry_i,
  output logic [IW-1:0] idx_o,
  output logic          last_o,
  output logic [W-1:0]  result_o,
  output logic          carry_o
);

  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;

  assign last_o = (idx_q == LAST_IDX);

  // Only the MSB's carry is kept; lower carries travel straight to the next cin.
  always_comb begin
    idx_d    = idx_q;
    result_d = result_q;
    carry_d  = carry_q;
    if (clear_i) begin
      idx_d    = '0;
      result_d = '0;
      carry_d  = 1'b0;
    end else if (load_i) begin
      idx_d = '0;
    end else if (capture_i) begin
      result_d[idx_q] = sum_i;
      if (last_o) carry_d = carry_i;
      else        idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign idx_o    = idx_q;
  assign result_o = result_q;
  assign carry_o  = carry_q;

endmodule

// File: rtl/alu_bit_sequencer.sv
// Runs the 1-bit serial ALU slice LSB-first across a W-bit word with a start/done handshake.
// Optional slice-hang watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_bit_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         binv,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero_flag,
  output logic         err,
  output logic         alu_a,
  output logic         alu_b,
  output logic         alu_op0,
  output logic         alu_op1,
  output logic         alu_binv,
  output logic         alu_cin,
  input  logic         alu_error,
  input  logic         alu_zero,
  input  logic         alu_y0,
  input  logic         alu_y1
);

  localparam int IW = $clog2(W);

  seq_state_t    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic          binv_q, binv_d;
  alu_drive_t    drv_q, drv_d;
  logic          err_q, err_d;

  logic          term, bit_sum, bit_cy, timeout;
  logic          sh_clear, sh_load, sh_capture, last;
  logic [IW-1:0] idx, nidx;
  logic [W-1:0]  res, a_nx, b_nx;

  assign term    = alu_error | alu_zero | alu_y0 | alu_y1;
  assign bit_sum = alu_zero ? 1'b0 : alu_y0;
  assign bit_cy  = alu_zero ? 1'b0 : alu_y1;
  assign nidx    = idx + 1'b1;
  assign a_nx    = a_q >> nidx;
  assign b_nx    = b_q >> nidx;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   to_cnt_q <= '0;
    else if (!(state_q inside {SYNC, RUN}) || term) to_cnt_q <= '0;
    else if (!timeout)                            to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout = (state_q inside {SYNC, RUN}) && !term && (to_cnt_q == TW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Drives change only on a terminal pulse, the one cycle the slice re-samples them.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    binv_d     = binv_q;
    drv_d      = drv_q;
    err_d      = err_q;
    sh_clear   = 1'b0;
    sh_load    = 1'b0;
    sh_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (term) drv_d = IDLE_DRIVE;
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          binv_d   = binv;
          err_d    = 1'b0;
          sh_clear = 1'b1;
          state_d  = SYNC;
        end
      end
      SYNC: begin
        if (term) begin
          drv_d.a    = a_q[0];
          drv_d.b    = b_q[0];
          drv_d.op1  = op_q[1];
          drv_d.op0  = op_q[0];
          drv_d.binv = binv_q;
          drv_d.cin  = binv_q;
          sh_load    = 1'b1;
          state_d    = RUN;
        end else if (timeout) begin
          err_d    = 1'b1;
          sh_clear = 1'b1;
          state_d  = DONE;
        end
      end
      RUN: begin
        if (term) begin
          if (alu_error) begin
            err_d    = 1'b1;
            sh_clear = 1'b1;
            drv_d    = IDLE_DRIVE;
            state_d  = DONE;
          end else begin
            sh_capture = 1'b1;
            if (last) begin
              drv_d   = IDLE_DRIVE;
              state_d = DONE;
            end else begin
              drv_d.a   = a_nx[0];
              drv_d.b   = b_nx[0];
              drv_d.cin = bit_cy;
            end
          end
        end else if (timeout) begin
          err_d    = 1'b1;
          sh_clear = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (term) drv_d = IDLE_DRIVE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ILL;
      binv_q  <= 1'b0;
      drv_q   <= IDLE_DRIVE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      binv_q  <= binv_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
    end
  end

  alu_result_shifter #(.W(W), .IW(IW)) u_shifter (
    .clk      (clk),
    .rst_n    (reset),
    .clear_i  (sh_clear),
    .load_i   (sh_load),
    .capture_i(sh_capture),
    .sum_i    (bit_sum),
    .carry_i  (bit_cy),
    .idx_o    (idx),
    .last_o   (last),
    .result_o (res),
    .carry_o  (carry_out)
  );

  assign busy      = (state_q == SYNC) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = res;
  assign zero_flag = (state_q == DONE) && (res == '0);
  assign err       = err_q;
  assign alu_a     = drv_q.a;
  assign alu_b     = drv_q.b;
  assign alu_op1   = drv_q.op1;
  assign alu_op0   = drv_q.op0;
  assign alu_binv  = drv_q.binv;
  assign alu_cin   = drv_q.cin;

endmodule

// File: tb/tb_alu_bit_sequencer.sv
// Directed bench for alu_bit_sequencer with a behavioural model of the serial slice.
module tb_alu_bit_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       binv = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       busy, done, carry_out, zero_flag, err;
  logic [7:0] result;
  logic       alu_a, alu_b, alu_op0, alu_op1, alu_binv, alu_cin;
  logic       s_err = 1'b0, s_zero = 1'b0, s_y0 = 1'b0, s_y1 = 1'b0;
  logic       slice_hold = 1'b0;
  int         st = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  alu_bit_sequencer #(.W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .binv(binv),
    .a(a_in), .b(b_in), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .zero_flag(zero_flag), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op0(alu_op0), .alu_op1(alu_op1),
    .alu_binv(alu_binv), .alu_cin(alu_cin),
    .alu_error(s_err), .alu_zero(s_zero), .alu_y0(s_y0), .alu_y1(s_y1)
  );

  // Slice model: samples its drives in the start state, pulses a few cycles later,
  // then spends one cycle returning to the start state.
  logic m_bb, m_sum, m_cy, term;
  assign m_bb = alu_b ^ alu_binv;
  assign term = s_err | s_zero | s_y0 | s_y1;
  always_comb begin
    m_sum = 1'b0;
    m_cy  = 1'b0;
    case ({alu_op1, alu_op0})
      2'b00:   m_sum = alu_a & m_bb;
      2'b01:   m_sum = alu_a | m_bb;
      default: begin
        m_sum = alu_a ^ m_bb ^ alu_cin;
        m_cy  = (alu_a & m_bb) | (alu_a & alu_cin) | (m_bb & alu_cin);
      end
    endcase
  end

  always @(posedge clk) begin
    s_err <= 1'b0; s_zero <= 1'b0; s_y0 <= 1'b0; s_y1 <= 1'b0;
    if (slice_hold) st <= 0;
    else case (st)
      0: st <= (alu_op1 && alu_op0) ? 2 : (alu_a ? 6 : 4);
      1: begin
        if (alu_op1 && alu_op0)  s_err  <= 1'b1;
        else if (!m_sum && !m_cy) s_zero <= 1'b1;
        else begin s_y0 <= m_sum; s_y1 <= m_cy; end
        st <= 99;
      end
      99:      st <= 0;
      default: st <= st - 1;
    endcase
  end

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                       input logic tbinv, output bit seen, output int ndone,
                       output logic [7:0] r, output logic co, output logic zf, output logic er);
    seen = 0; ndone = 0; r = '0; co = 1'b0; zf = 1'b0; er = 1'b0;
    @(negedge clk); a_in = ta; b_in = tb; op = top; binv = tbinv; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1; ndone++;
        r = result; co = carry_out; zf = zero_flag; er = err;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, result, carry_out, zero_flag, err} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b required 0", {busy, done, result, carry_out, zero_flag, err});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op1, alu_op0, alu_binv, alu_cin} !== 6'b001100) begin
      n_fail++;
      $display("FAIL reset_drives got %b required 001100", {alu_a, alu_b, alu_op1, alu_op0, alu_binv, alu_cin});
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({busy, done, alu_op1, alu_op0} !== 4'b0011) begin
      n_fail++;
      $display("FAIL idle_spin got %b required 0011", {busy, done, alu_op1, alu_op0});
    end
  endtask

  task automatic test_add();
    bit seen; int nd; logic [7:0] r; logic co, zf, er;
    do_op(8'h05, 8'h03, 2'b10, 1'b0, seen, nd, r, co, zf, er);
    n_checks++; if (!seen)      begin n_fail++; $display("FAIL add_done no done within bound"); end
    n_checks++; if (nd !== 1)   begin n_fail++; $display("FAIL add_done_count got %0d required 1", nd); end
    n_checks++; if (r !== 8'h08) begin n_fail++; $display("FAIL add_result got %h required 08", r); end
    n_checks++; if ({co, zf, er} !== 3'b000) begin n_fail++; $display("FAIL add_flags got %b required 000", {co, zf, er}); end
  endtask

  task automatic test_sub();
    bit seen; int nd; logic [7:0] r; logic co, zf, er;
    do_op(8'h05, 8'h03, 2'b10, 1'b1, seen, nd, r, co, zf, er);
    n_checks++; if (!seen || nd !== 1) begin n_fail++; $display("FAIL sub_done seen %0d count %0d required 1 1", seen, nd); end
    n_checks++; if (r !== 8'h02) begin n_fail++; $display("FAIL sub_result got %h required 02", r); end
    n_checks++; if ({co, zf, er} !== 3'b100) begin n_fail++; $display("FAIL sub_flags got %b required 100", {co, zf, er}); end
  endtask

  task automatic test_add_overflow();
    bit seen; int nd; logic [7:0] r; logic co, zf, er;
    do_op(8'hFF, 8'h01, 2'b10, 1'b0, seen, nd, r, co, zf, er);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL ovf_done no done within bound"); end
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL ovf_result got %h required 00", r); end
    n_checks++; if ({co, zf, er} !== 3'b110) begin n_fail++; $display("FAIL ovf_flags got %b required 110", {co, zf, er}); end
  endtask

  task automatic test_logic();
    bit seen; int nd; logic [7:0] r; logic co, zf, er;
    do_op(8'hF0, 8'h3C, 2'b00, 1'b0, seen, nd, r, co, zf, er);
    n_checks++; if (!seen || r !== 8'h30) begin n_fail++; $display("FAIL and_result got %h seen %0d required 30", r, seen); end
    n_checks++; if ({zf, er} !== 2'b00) begin n_fail++; $display("FAIL and_flags got %b required 00", {zf, er}); end
    do_op(8'hF0, 8'h3C, 2'b01, 1'b0, seen, nd, r, co, zf, er);
    n_checks++; if (!seen || r !== 8'hFC) begin n_fail++; $display("FAIL or_result got %h seen %0d required fc", r, seen); end
    n_checks++; if ({zf, er} !== 2'b00) begin n_fail++; $display("FAIL or_flags got %b required 00", {zf, er}); end
  endtask

  task automatic test_reset_mid_run();
    bit seen; int nd; int nterm; logic [7:0] r; logic co, zf, er;
    nterm = 0; nd = 0;
    @(negedge clk); a_in = 8'h55; b_in = 8'h0F; op = 2'b10; binv = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 1000 && nterm < 5; i++) begin
      @(negedge clk);
      if (term && busy) nterm++;
    end
    n_checks++; if (nterm !== 5) begin n_fail++; $display("FAIL midrun_reach got %0d pulses required 5", nterm); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result} !== 10'h0) begin
      n_fail++;
      $display("FAIL midrun_abort busy %b done %b result %h required 0 0 00", busy, done, result);
    end
    repeat (3) begin @(negedge clk); if (done) nd++; end
    reset = 1'b1;
    repeat (20) begin @(negedge clk); if (done) nd++; end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL midrun_no_done got %0d done pulses required 0", nd); end
    do_op(8'h12, 8'h34, 2'b10, 1'b0, seen, nd, r, co, zf, er);
    n_checks++; if (!seen || r !== 8'h46) begin n_fail++; $display("FAIL after_reset_add got %h seen %0d required 46", r, seen); end
    n_checks++; if ({co, zf, er} !== 3'b000) begin n_fail++; $display("FAIL after_reset_flags got %b required 000", {co, zf, er}); end
  endtask

  task automatic test_illegal();
    bit seen; int nd; logic [7:0] r; logic er;
    seen = 0; nd = 0; r = '0; er = 1'b0;
    @(negedge clk); a_in = 8'hAA; b_in = 8'h55; op = 2'b11; binv = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ill_busy got %b required 1", busy); end
    a_in = 8'h01; b_in = 8'h01; op = 2'b10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; r = result; er = err; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL ill_done no done within bound"); end
    n_checks++; if ({er, r} !== 9'h100) begin n_fail++; $display("FAIL ill_result err %b result %h required 1 00", er, r); end
    repeat (150) begin @(negedge clk); if (done || busy) nd++; end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL ill_start_ignored got %0d active cycles required 0", nd); end
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit seen; int nd; logic [7:0] r; logic co, zf, er;
    slice_hold = 1'b1;
    do_op(8'h05, 8'h03, 2'b10, 1'b0, seen, nd, r, co, zf, er);
    slice_hold = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL timeout_done no done within bound"); end
    n_checks++; if ({er, r} !== 9'h100) begin n_fail++; $display("FAIL timeout_result err %b result %h required 1 00", er, r); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_add_overflow();
    test_logic();
    test_reset_mid_run();
    test_illegal();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
